// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and default limits for mem_port_arbiter and its grant selector.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_STARVE_MAX  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY_IF = ST_BUSY_IF,
        BUSY_D  = ST_BUSY_D
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_grant_sel.sv
// Grant decision between fetch and data requesters, with the fetch starvation counter.
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_if_o,
    output logic grant_d_o
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
    logic             fetch_due;

    // Data normally wins; a fetch that has watched STARVE_MAX data grants goes next.
    always_comb begin
        fetch_due    = if_req_i && (starve_cnt_q == STARVE_LIM);
        grant_d_o    = idle_i && d_req_i && !fetch_due;
        grant_if_o   = idle_i && if_req_i && !grant_d_o;
        starve_cnt_d = starve_cnt_q;
        if (grant_if_o || (idle_i && !if_req_i)) begin
            starve_cnt_d = '0;
        end else if (grant_d_o && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with registered memory outputs.
// Define MEM_ARB_TIMEOUT_EN to add the BUSY watchdog and the sticky err_o flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned STARVE_MAX  = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o,
    output logic              err_o
);

    arb_state_e        state_d, state_q;
    logic              mem_req_d, mem_req_q;
    logic              mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
    logic [DATA_W-1:0] d_rdata_d, d_rdata_q;
    logic              if_ack_d, if_ack_q;
    logic              d_ack_d, d_ack_q;
    logic              idle, busy, done, timed_out;
    logic              grant_if, grant_d;
    logic [DATA_W-1:0] resp_data;

    assign idle = (state_q == IDLE);
    assign busy = !idle;

    arb_grant_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idle_i     (idle),
        .if_req_i   (if_req_i),
        .d_req_i    (d_req_i),
        .grant_if_o (grant_if),
        .grant_d_o  (grant_d)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             err_d, err_q;

    // Down-counter loaded at grant; reaching zero on a cycle without ready ends the access.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (grant_if || grant_d) begin
            tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
        end else if (busy && (tmo_cnt_q != '0)) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
        err_d = err_q | timed_out;
    end

    assign timed_out = busy && !mem_ready_i && (tmo_cnt_q == '0);
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign done      = busy && (mem_ready_i || timed_out);
    assign resp_data = mem_ready_i ? mem_rdata_i : '0;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if (idle) begin
            if (grant_d) begin
                state_d     = BUSY_D;
                mem_req_d   = 1'b1;
                mem_we_d    = d_we_i;
                mem_addr_d  = d_addr_i;
                mem_wdata_d = d_wdata_i;
            end else if (grant_if) begin
                state_d     = BUSY_IF;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr_i;
                mem_wdata_d = '0;
            end
        end else if (done) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            if (state_q == BUSY_IF) begin
                if_ack_d   = 1'b1;
                if_rdata_d = resp_data;
            end else begin
                d_ack_d = 1'b1;
                // Writes complete without disturbing the last read data.
                if (!mem_we_q) begin
                    d_rdata_d = resp_data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level requester/memory model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STARVE_MAX  = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              d_req_i = 1'b0;
    logic              d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [DATA_W-1:0] d_wdata_i = '0;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              mem_ready_i = 1'b0;
    logic              stall_o;
    logic              err_o;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_MAX  (STARVE_MAX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        if_q[$];
    txn_t        d_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    bit          m_busy = 0;
    txn_t        m_cur;
    int          m_starve = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;
    bit          m_err = 0;
    int          busy_cnt = 0;
    int          lat = 1;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          idle_noise = 0;
    bit          drop_en = 0;
    bit          fixed_rd_en = 0;
    logic [31:0] fixed_rd = '0;
    bit          prev_if = 0, prev_d = 0, prev_ready = 0;
    logic [31:0] prev_rdata = '0;
    bit          exp_if_ack = 0, exp_d_ack = 0;
    string       grants = "";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk_fetch(input logic [31:0] addr);
        txn_t t;
        t.is_d = 0; t.we = 0; t.addr = addr; t.wdata = '0;
        return t;
    endfunction

    function automatic txn_t mk_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.is_d = 1; t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    // One clock: advance the reference model, compare every output, then drive the next inputs.
    task automatic cycle();
        bit          gnt_if, gnt_d, tmo;
        logic [31:0] rd;
        @(posedge clk_i);
        #1;
        exp_if_ack = 0;
        exp_d_ack  = 0;
        tmo        = 0;
        if (m_busy) begin
`ifdef MEM_ARB_TIMEOUT_EN
            tmo = !prev_ready && (busy_cnt == TIMEOUT_CYC);
`endif
            if (prev_ready || tmo) begin
                rd = prev_ready ? prev_rdata : 32'h0;
                if (m_cur.is_d) begin
                    exp_d_ack = 1;
                    if (!m_cur.we) m_d_rdata = rd;
                    void'(d_q.pop_front());
                end else begin
                    exp_if_ack = 1;
                    m_if_rdata = rd;
                    void'(if_q.pop_front());
                end
                if (tmo) m_err = 1;
                m_busy = 0;
            end
        end else begin
            gnt_d  = prev_d && !(prev_if && (m_starve == STARVE_MAX));
            gnt_if = prev_if && !gnt_d;
            if (gnt_d) begin
                m_cur    = d_q[0];
                m_starve = prev_if ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
                grants   = {grants, "D"};
            end else if (gnt_if) begin
                m_cur    = if_q[0];
                m_starve = 0;
                grants   = {grants, "F"};
            end else if (!prev_if) begin
                m_starve = 0;
            end
            if (gnt_d || gnt_if) begin
                m_busy   = 1;
                busy_cnt = 0;
                lat      = (lat_max == 0) ? 0 : int'($urandom_range(lat_min, lat_max));
            end
        end

        check("if_ack", if_ack_o, exp_if_ack);
        check("d_ack", d_ack_o, exp_d_ack);
        check("if_rdata", if_rdata_o, m_if_rdata);
        check("d_rdata", d_rdata_o, m_d_rdata);
        check("mem_req", mem_req_o, m_busy);
        check("err", err_o, m_err);
        if (m_busy) begin
            check("mem_we", mem_we_o, m_cur.we);
            check("mem_addr", mem_addr_o, m_cur.addr);
            check("mem_wdata", mem_wdata_o, m_cur.wdata);
        end

        if_req_i  = (if_q.size() > 0);
        if_addr_i = if_req_i ? if_q[0].addr : '0;
        d_req_i   = (d_q.size() > 0);
        d_we_i    = d_req_i ? d_q[0].we : 1'b0;
        d_addr_i  = d_req_i ? d_q[0].addr : '0;
        d_wdata_i = d_req_i ? d_q[0].wdata : '0;
        if (m_busy && drop_en && ($urandom_range(0, 1) == 1)) begin
            if (m_cur.is_d) d_req_i = 1'b0;
            else            if_req_i = 1'b0;
        end

        mem_ready_i = 1'b0;
        mem_rdata_i = $urandom();
        if (m_busy) begin
            busy_cnt++;
            if ((lat != 0) && (busy_cnt == lat)) begin
                mem_ready_i = 1'b1;
                if (fixed_rd_en) mem_rdata_i = fixed_rd;
            end
        end else if (idle_noise) begin
            mem_ready_i = 1'($urandom_range(0, 1));
        end
        prev_if    = if_req_i;
        prev_d     = d_req_i;
        prev_ready = m_busy && mem_ready_i;
        prev_rdata = mem_rdata_i;

        #1;
        check("stall", stall_o, (if_req_i && !exp_if_ack) || (d_req_i && !exp_d_ack));
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (((if_q.size() > 0) || (d_q.size() > 0) || m_busy) && (n < max_cyc)) begin
            cycle();
            n++;
        end
        check("drain_in_budget", (n < max_cyc), 1'b1);
    endtask

    task automatic clear_model();
        if_q.delete();
        d_q.delete();
        m_busy = 0; m_starve = 0; m_err = 0;
        m_if_rdata = '0; m_d_rdata = '0;
        prev_if = 0; prev_d = 0; prev_ready = 0;
        if_req_i = 0; d_req_i = 0; d_we_i = 0;
        if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_ready_i = 0;
    endtask

    initial begin
        // Asynchronous reset, observed before any clock edge.
        #2 rst_i = 1'b0;
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_acks", {if_ack_o, d_ack_o}, 2'b00);
        check("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b1;
        repeat (2) cycle();

        // Fetch only, ready on the third BUSY cycle.
        grants = ""; lat_min = 3; lat_max = 3; fixed_rd_en = 1; fixed_rd = 32'h0050_0093;
        if_q.push_back(mk_fetch(32'h10));
        run_until_idle(20);
        check_str("fetch_only_grants", grants, "F");
        check("fetch_only_rdata", if_rdata_o, 32'h0050_0093);
        fixed_rd_en = 0;

        // Simultaneous requests: data write first, then fetch.
        grants = ""; lat_min = 1; lat_max = 1;
        d_q.push_back(mk_data(1, 32'h40, 32'hCAFE));
        if_q.push_back(mk_fetch(32'h20));
        run_until_idle(20);
        check_str("both_req_order", grants, "DF");
        repeat (2) cycle();

        // Starvation limit with fetch held and continuous data traffic.
        grants = "";
        for (int i = 0; i < 10; i++) d_q.push_back(mk_data(0, 32'h100 + 4 * i, 32'h0));
        if_q.push_back(mk_fetch(32'h200));
        if_q.push_back(mk_fetch(32'h204));
        run_until_idle(60);
        check_str("starve_order", grants, "DDDDFDDDDFDD");
        repeat (2) cycle();

        // mem_ready pulses while idle must be ignored.
        grants = ""; idle_noise = 1;
        repeat (12) cycle();
        check_str("idle_ready_no_grant", grants, "");
        idle_noise = 0;

        // Memory never answers.
        grants = ""; lat_min = 0; lat_max = 0;
        d_q.push_back(mk_data(0, 32'h80, 32'h0));
`ifdef MEM_ARB_TIMEOUT_EN
        run_until_idle(TIMEOUT_CYC + 10);
        check("tmo_rdata", d_rdata_o, 32'h0);
        repeat (3) cycle();
        check("tmo_err_sticky", err_o, 1'b1);
`else
        repeat (40) cycle();
        check("no_tmo_still_busy", mem_req_o, 1'b1);
        check("no_tmo_err", err_o, 1'b0);
        lat = busy_cnt + 1;
        run_until_idle(10);
`endif
        check_str("no_answer_grants", grants, "D");

        // Reset in the middle of a data access.
        grants = "";
        d_q.push_back(mk_data(0, 32'h84, 32'h0));
        while (!m_busy) cycle();
        cycle();
        #2 rst_i = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req_o, 1'b0);
        check("rst_mid_d_ack", d_ack_o, 1'b0);
        clear_model();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b1;
        grants = "";
        repeat (4) cycle();
        check_str("rst_no_residue", grants, "");
        lat_min = 1; lat_max = 1;
        if_q.push_back(mk_fetch(32'h300));
        run_until_idle(10);
        check_str("post_rst_fetch", grants, "F");

        // Randomized mix: varying latency, idle ready noise, requests dropped mid-access.
        lat_min = 1; lat_max = 4; idle_noise = 1; drop_en = 1;
        for (int i = 0; i < 300; i++) begin
            if ((if_q.size() < 2) && ($urandom_range(0, 2) == 0))
                if_q.push_back(mk_fetch($urandom()));
            if ((d_q.size() < 2) && ($urandom_range(0, 1) == 0))
                d_q.push_back(mk_data(1'($urandom_range(0, 1)), $urandom(), $urandom()));
            cycle();
        end
        run_until_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
